// File: rtl/frame_read_arbiter.sv
// rtl/frame_read_arbiter.sv - shares the SDRAM frame-buffer read port between display and resize, sequences resize passes
module frame_read_arbiter #(
  parameter int          RD_LAT  = 2,
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_n,
  input  logic        vsync,
  input  logic        disp_req,
  input  logic [22:0] disp_addr,
  output logic        disp_rvalid,
  output logic [7:0]  disp_rdata,
  input  logic        rsz_req,
  input  logic [22:0] rsz_addr,
  output logic        rsz_gnt,
  output logic        rsz_rvalid,
  output logic [7:0]  rsz_rdata,
  output logic        rsz_start,
  input  logic        rsz_done,
  output logic        mem_rd,
  output logic [22:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        capture_pause,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Last DRAIN cycle index: DRAIN lasts exactly RD_LAT cycles so every read
  // granted in the final RUN cycle has its tag retired before IDLE.
  localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT - 1);

  state_t state_q, state_d;

  // Pushbutton idles high, so its synchroniser resets to 1 to avoid a
  // phantom press coming out of reset.
  logic key_s1_q, key_s1_d;
  logic key_s2_q, key_s2_d;
  logic key_s3_q, key_s3_d;
  logic vs_s1_q, vs_s1_d;
  logic vs_s2_q, vs_s2_d;
  logic vs_s3_q, vs_s3_d;
  logic key_press;
  logic vs_edge;

  logic [23:0] wdog_q, wdog_d;
  logic [3:0]  drain_q, drain_d;
  logic        cap_q, cap_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        mem_rd_q, mem_rd_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic        rd_issue;

  // Owner tag per in-flight read: stage 0 travels alongside mem_rd.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_rsz_q, tag_rsz_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic              rsz_rvalid_q, rsz_rvalid_d;

  // Synchroniser shift and edge detection for the two asynchronous inputs
  always_comb begin
    key_s1_d  = key_n;
    key_s2_d  = key_s1_q;
    key_s3_d  = key_s2_q;
    vs_s1_d   = vsync;
    vs_s2_d   = vs_s1_q;
    vs_s3_d   = vs_s2_q;
    key_press = key_s3_q & ~key_s2_q;
    vs_edge   = vs_s2_q & ~vs_s3_q;
  end

  // Pass sequencer: next state, watchdog, drain counter and pass outputs
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    drain_d = drain_q;
    cap_d   = cap_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (key_press) begin
          state_d = ST_ARM;
          err_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (vs_edge) begin
          state_d = ST_RUN;
          cap_d   = 1'b1;
          start_d = 1'b1;
          wdog_d  = 24'd0;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + 24'd1;
        // A done arriving on the timeout cycle counts as a normal finish.
        if (rsz_done) begin
          state_d = ST_DRAIN;
          drain_d = 4'd0;
        end else if (wdog_q == TIMEOUT - 24'd1) begin
          state_d = ST_DRAIN;
          drain_d = 4'd0;
          err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cap_d   = 1'b0;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port arbitration: display has hard priority, resize only in RUN gaps
  always_comb begin
    rsz_gnt    = rsz_req & ~disp_req & (state_q == ST_RUN);
    rd_issue   = disp_req | rsz_gnt;
    mem_rd_d   = rd_issue;
    mem_addr_d = mem_addr_q;
    if (rd_issue) begin
      mem_addr_d = disp_req ? disp_addr : rsz_addr;
    end
  end

  // Owner tag pipeline and return steering
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_rsz_d    = tag_rsz_q;
    tag_vld_d[0] = rd_issue;
    tag_rsz_d[0] = ~disp_req;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_rsz_d[i] = tag_rsz_q[i-1];
    end
    disp_rvalid_d = tag_vld_q[RD_LAT-1] & ~tag_rsz_q[RD_LAT-1];
    rsz_rvalid_d  = tag_vld_q[RD_LAT-1] &  tag_rsz_q[RD_LAT-1];
  end

  // State registers; reset discards every in-flight tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      key_s1_q      <= 1'b1;
      key_s2_q      <= 1'b1;
      key_s3_q      <= 1'b1;
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      vs_s3_q       <= 1'b0;
      wdog_q        <= 24'd0;
      drain_q       <= 4'd0;
      cap_q         <= 1'b0;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= 23'd0;
      tag_vld_q     <= '0;
      tag_rsz_q     <= '0;
      disp_rvalid_q <= 1'b0;
      rsz_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      key_s3_q      <= key_s3_d;
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      vs_s3_q       <= vs_s3_d;
      wdog_q        <= wdog_d;
      drain_q       <= drain_d;
      cap_q         <= cap_d;
      start_q       <= start_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      tag_vld_q     <= tag_vld_d;
      tag_rsz_q     <= tag_rsz_d;
      disp_rvalid_q <= disp_rvalid_d;
      rsz_rvalid_q  <= rsz_rvalid_d;
    end
  end

  // Read data arrives in the rvalid cycle, so it is passed straight through
  // and gated to zero whenever no return is due.
  assign disp_rvalid   = disp_rvalid_q;
  assign rsz_rvalid    = rsz_rvalid_q;
  assign disp_rdata    = disp_rvalid_q ? mem_rdata : 8'h00;
  assign rsz_rdata     = rsz_rvalid_q ? mem_rdata : 8'h00;
  assign rsz_start     = start_q;
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign capture_pause = cap_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_frame_read_arbiter.sv
// tb/tb_frame_read_arbiter.sv - randomized bench for frame_read_arbiter against a cycle-level reference model
module tb_frame_read_arbiter;
  localparam int RD_LAT = 2;
  localparam int TMO    = 1000;

  logic        clk = 1'b0;
  logic        rst_n, key_n, vsync;
  logic        disp_req, rsz_req, rsz_done;
  logic [22:0] disp_addr, rsz_addr;
  logic [7:0]  mem_rdata;
  logic        disp_rvalid, rsz_rvalid, rsz_gnt, rsz_start, mem_rd;
  logic        capture_pause, busy, done, err;
  logic [7:0]  disp_rdata, rsz_rdata;
  logic [22:0] mem_addr;

  always #5 clk = ~clk;

  frame_read_arbiter #(.RD_LAT(RD_LAT), .TIMEOUT(24'(TMO))) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .vsync(vsync),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .rsz_req(rsz_req), .rsz_addr(rsz_addr), .rsz_gnt(rsz_gnt),
    .rsz_rvalid(rsz_rvalid), .rsz_rdata(rsz_rdata),
    .rsz_start(rsz_start), .rsz_done(rsz_done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .capture_pause(capture_pause), .busy(busy), .done(done), .err(err)
  );

  typedef enum int {M_IDLE, M_WAIT_ARM, M_ARM, M_WAIT_RUN, M_RUN, M_DRAIN} mode_t;
  typedef struct {int due; logic is_rsz; logic [7:0] data;} ret_t;
  typedef struct {int due; logic [7:0] data;} mem_t;

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  mode_t       mode;
  int          wait_cnt, run_start, drain_last, done_cyc;
  logic        exp_err, exp_mrd;
  logic [22:0] last_addr;
  logic        rq_pend, no_new, traffic_on;
  logic [22:0] rq_addr;
  ret_t        exp_q[$];
  mem_t        mem_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mem_f(input logic [22:0] a);
    if (a == 23'h000100) return 8'h58;
    if (a == 23'h000200) return 8'h3C;
    return a[7:0] ^ a[22:15] ^ 8'h5A;
  endfunction

  task automatic check_cycle();
    logic        exp_gnt, acc, edv, erv;
    logic [7:0]  edat;
    logic [22:0] acc_addr;
    ret_t        r;
    mem_t        m;
    if (mode == M_WAIT_ARM) begin
      if (busy) begin
        mode    = M_ARM;
        exp_err = 1'b0;
      end else begin
        wait_cnt++;
        if (wait_cnt > 8) begin
          chk("arm_wait", 32'd0, 32'd1);
          mode = M_IDLE;
        end
      end
    end
    if (mode == M_WAIT_RUN) begin
      if (rsz_start) begin
        mode      = M_RUN;
        run_start = cyc;
      end else begin
        wait_cnt++;
        if (wait_cnt > 8) begin
          chk("run_wait", 32'd0, 32'd1);
          mode = M_ARM;
        end
      end
    end
    if (mode != M_WAIT_ARM) begin
      chk("busy", 32'(busy), 32'(mode != M_IDLE));
      chk("capture_pause", 32'(capture_pause), 32'(mode == M_RUN || mode == M_DRAIN));
      chk("err", 32'(err), 32'(exp_err));
    end
    chk("rsz_start", 32'(rsz_start), 32'(mode == M_RUN && cyc == run_start));
    chk("done", 32'(done), 32'(cyc == done_cyc));
    exp_gnt = rsz_req & ~disp_req & (mode == M_RUN);
    chk("rsz_gnt", 32'(rsz_gnt), 32'(exp_gnt));
    chk("mem_rd", 32'(mem_rd), 32'(exp_mrd));
    chk("mem_addr", 32'(mem_addr), 32'(last_addr));
    edv = 1'b0; erv = 1'b0; edat = 8'h00;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r    = exp_q.pop_front();
      edv  = ~r.is_rsz;
      erv  = r.is_rsz;
      edat = r.data;
    end
    chk("disp_rvalid", 32'(disp_rvalid), 32'(edv));
    chk("rsz_rvalid", 32'(rsz_rvalid), 32'(erv));
    if (edv) chk("disp_rdata", 32'(disp_rdata), 32'(edat));
    if (erv) chk("rsz_rdata", 32'(rsz_rdata), 32'(edat));
    // frame-buffer memory: answers whatever the port asks for
    if (mem_rd) begin
      m.due  = cyc + RD_LAT;
      m.data = mem_f(mem_addr);
      mem_q.push_back(m);
    end
    // reference model update for the next cycle
    acc      = rst_n && (disp_req || exp_gnt);
    acc_addr = disp_req ? disp_addr : rsz_addr;
    if (acc) begin
      r.due    = cyc + 1 + RD_LAT;
      r.is_rsz = ~disp_req;
      r.data   = mem_f(acc_addr);
      exp_q.push_back(r);
      last_addr = acc_addr;
    end
    exp_mrd = acc;
    if (exp_gnt) rq_pend = 1'b0;
    if (mode == M_RUN) begin
      if (rsz_done) begin
        mode       = M_DRAIN;
        drain_last = cyc + RD_LAT;
      end else if (cyc - run_start == TMO - 1) begin
        mode       = M_DRAIN;
        drain_last = cyc + RD_LAT;
        exp_err    = 1'b1;
      end
    end else if (mode == M_DRAIN && cyc == drain_last) begin
      mode     = M_IDLE;
      done_cyc = cyc + 1;
    end
    if (!rst_n) begin
      mode      = M_IDLE;
      exp_q.delete();
      last_addr = 23'd0;
      exp_mrd   = 1'b0;
      exp_err   = 1'b0;
      done_cyc  = -1;
    end
  endtask

  task automatic step();
    mem_t m;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = 8'($urandom);
    while (mem_q.size() > 0 && mem_q[0].due < cyc) m = mem_q.pop_front();
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      m         = mem_q.pop_front();
      mem_rdata = m.data;
    end
    rsz_done = 1'b0;
    if (traffic_on) begin
      disp_req  = ($urandom_range(0, 9) < 4);
      disp_addr = 23'($urandom);
      if (!rq_pend && !no_new && $urandom_range(0, 1) == 1) begin
        rq_pend = 1'b1;
        rq_addr = 23'($urandom);
      end
    end else begin
      disp_req = 1'b0;
    end
    rsz_req  = rq_pend;
    rsz_addr = rq_addr;
  endtask

  task automatic run_pass(input bit tmo, input bit do_rst);
    int len;
    for (int i = 0; i < 8; i++) begin
      step();
      rsz_done = ($urandom_range(0, 3) == 0);
    end
    step();
    key_n    = 1'b0;
    mode     = M_WAIT_ARM;
    wait_cnt = 0;
    repeat (4) step();
    key_n = 1'b1;
    for (int i = 0; i < 12 && mode == M_WAIT_ARM; i++) step();
    if (mode != M_ARM) return;
    repeat (10) step();
    vsync    = 1'b1;
    mode     = M_WAIT_RUN;
    wait_cnt = 0;
    for (int i = 0; i < 12 && mode == M_WAIT_RUN; i++) begin
      step();
      if (i == 2) vsync = 1'b0;
    end
    vsync = 1'b0;
    if (mode != M_RUN) return;
    if (!tmo) begin
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
        step();
        key_n = !(i >= 3 && i < 6);
        vsync = (i >= 15 && i < 18);
        if (i == 4) no_new = 1'b1;
        if (i == 5 || i == 6) disp_req = 1'b0;
        if (i == 8) begin
          disp_req  = 1'b1;
          disp_addr = 23'h000100;
          rq_pend   = 1'b1;
          rq_addr   = 23'h000200;
          rsz_req   = 1'b1;
          rsz_addr  = 23'h000200;
        end
        if (i == 9) disp_req = 1'b0;
        if (i == 10) no_new = 1'b0;
        if (do_rst && i == 12) begin
          rst_n    = 1'b0;
          disp_req = 1'b0;
          rsz_req  = 1'b0;
          rq_pend  = 1'b0;
        end
        if (do_rst && i == 13) begin
          rst_n = 1'b1;
          break;
        end
      end
      key_n = 1'b1;
      vsync = 1'b0;
      if (mode == M_RUN) begin
        rsz_done = 1'b1;
        step();
      end
    end else begin
      for (int i = 0; i < TMO + 20 && mode != M_IDLE; i++) step();
    end
    for (int i = 0; i < RD_LAT + 10 && mode != M_IDLE; i++) step();
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0; key_n = 1'b1; vsync = 1'b0; rsz_done = 1'b0;
    disp_req = 1'b0; disp_addr = 23'd0; rsz_req = 1'b0; rsz_addr = 23'd0;
    mem_rdata = 8'h00;
    rq_pend = 1'b0; rq_addr = 23'd0; no_new = 1'b0; traffic_on = 1'b0;
    mode = M_IDLE; exp_err = 1'b0; exp_mrd = 1'b0; last_addr = 23'd0;
    done_cyc = -1; run_start = -1; drain_last = -1; wait_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    traffic_on = 1'b1;
    run_pass(1'b0, 1'b0);
    run_pass(1'b0, 1'b0);
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);
    run_pass(1'b0, 1'b1);
    run_pass(1'b0, 1'b0);
    traffic_on = 1'b0;
    repeat (RD_LAT + 4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
